// File: rtl/writeback_queue_if.sv
// Bundle between the execute/load stage, the write-back queue and the register file.
// Also carries the decode-stage hazard query and the occupancy count.
interface writeback_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [63:0]      in_data;
    logic             wb_valid;
    logic             wb_ready;
    logic             RegWrite;
    logic [4:0]       wb_rd;
    logic [63:0]      WriteData;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             hazard_rs;
    logic             hazard_rt;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_opcode, in_rd, in_data, wb_ready, rs, rt,
        input  in_ready, wb_valid, RegWrite, wb_rd, WriteData, hazard_rs, hazard_rt, count
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_data, wb_ready, rs, rt,
        output in_ready, wb_valid, RegWrite, wb_rd, WriteData, hazard_rs, hazard_rt, count
    );
endinterface

// File: rtl/writeback_queue.sv
// Write-back queue: formats load results at enqueue, then retires them in order
// to the register file write port while flagging RAW hazards on queued rds.
module writeback_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_queue_if.slave bus
);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      dataMem_q [DEPTH];
    logic [4:0]       rdMem_q   [DEPTH];

    logic             inReady;
    logic             wbValid;
    logic             doEnq;
    logic             doDeq;
    logic [63:0]      fmtData;
    logic             hazRs;
    logic             hazRt;
    logic [PTR_W-1:0] slot;

    // Handshake outputs are held inactive while reset is asserted so no write escapes the reset cycle.
    assign inReady = rst_n && (count_q != CNT_W'(DEPTH));
    assign wbValid = rst_n && (count_q != '0);
    assign doEnq   = bus.in_valid && inReady;
    assign doDeq   = wbValid && bus.wb_ready;

    assign bus.in_ready  = inReady;
    assign bus.wb_valid  = wbValid;
    assign bus.RegWrite  = doDeq;
    assign bus.wb_rd     = rdMem_q[headPtr_q];
    assign bus.WriteData = dataMem_q[headPtr_q];
    assign bus.count     = count_q;
    assign bus.hazard_rs = hazRs;
    assign bus.hazard_rt = hazRt;

    always_comb begin
        fmtData = bus.in_data;
        case (bus.in_opcode)
            6'd34:   fmtData = {56'd0, bus.in_data[7:0]};
            6'd40:   fmtData = {48'd0, bus.in_data[15:0]};
            6'd42:   fmtData = {{48{bus.in_data[15]}}, bus.in_data[15:0]};
            6'd32:   fmtData = {32'd0, bus.in_data[31:0]};
            default: fmtData = bus.in_data;
        endcase
    end

    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (doEnq) begin
            tailPtr_d = tailPtr_q + PTR_W'(1);
        end
        if (doDeq) begin
            headPtr_d = headPtr_q + PTR_W'(1);
        end
        case ({doEnq, doDeq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk occupied slots from the head; the entry retiring this cycle is still occupied.
    always_comb begin
        hazRs = 1'b0;
        hazRt = 1'b0;
        slot  = headPtr_q;
        for (int i = 0; i < DEPTH; i++) begin
            slot = headPtr_q + PTR_W'(i);
            if (rst_n && (CNT_W'(i) < count_q)) begin
                if (rdMem_q[slot] == bus.rs) hazRs = 1'b1;
                if (rdMem_q[slot] == bus.rt) hazRt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doEnq) begin
            dataMem_q[tailPtr_q] <= fmtData;
            rdMem_q[tailPtr_q]   <= bus.in_rd;
        end
    end
endmodule
